// File: rtl/uart_ctrl.sv
// uart_ctrl: byte-level 8N1 UART responder behind the memory bridge.
// A TX path serialises one accepted byte at a time onto txd_o. An RX path
// deserialises rxd_i into a single-byte buffer with ready and sticky overrun flags.
module uart_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_we_n_i,
  input  logic       uart_re_n_i,
  input  logic       uart_re_data_i,
  input  logic [7:0] uart_tx_data_i,
  output logic       uart_tx_ready_o,
  output logic       uart_rx_ready_o,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_ovr_o,
  output logic       txd_o,
  input  logic       rxd_i
);

  localparam int CLK_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------- TX path
  state_t           tx_state, tx_state_d;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]       tx_bit, tx_bit_d;
  logic [7:0]       tx_shift, tx_shift_d;
  logic             txd_d, tx_ready_d;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt == DIV_LAST);

  // TX next-state: one CLK_DIV-long slot per frame bit; txd_o is registered.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latch).
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    txd_d      = txd_o;
    tx_ready_d = uart_tx_ready_o;
    unique case (tx_state)
      S_IDLE: begin
        if (!uart_we_n_i && uart_tx_ready_o) begin
          tx_state_d = S_START;
          tx_shift_d = uart_tx_data_i;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift[0];
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit + 1'b1;
            tx_shift_d = {1'b0, tx_shift[7:1]};
            txd_d      = tx_shift[1];
          end
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = '0;
          tx_ready_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // TX state register; reset forces the line idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state        <= S_IDLE;
      tx_cnt          <= '0;
      tx_bit          <= '0;
      tx_shift        <= '0;
      txd_o           <= 1'b1;
      uart_tx_ready_o <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      tx_state        <= tx_state_d;
      tx_cnt          <= tx_cnt_d;
      tx_bit          <= tx_bit_d;
      tx_shift        <= tx_shift_d;
      txd_o           <= txd_d;
      uart_tx_ready_o <= tx_ready_d;
    end
  end

  // ---------------------------------------------------------------- RX path
  logic rx_meta, rxs, rxs_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd_i;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  state_t           rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_bit, rx_bit_d;
  logic [7:0]       rx_shift, rx_shift_d;
  logic [7:0]       rx_data_d;
  logic             rx_ready_d, rx_ovr_d;
  logic             data_read;

  assign data_read = !uart_re_n_i && uart_re_data_i;

  // RX next-state: mid-bit sampling; a completed byte overrides a same-cycle read.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_data_d  = uart_rx_data_o;
    rx_ready_d = uart_rx_ready_o;
    rx_ovr_d   = uart_rx_ovr_o;
    if (data_read) begin
      rx_ready_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    unique case (rx_state)
      S_IDLE: begin
        if (rxs_prev && !rxs) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_d = S_STOP;
          else                rx_bit_d   = rx_bit + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt == DIV_LAST) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = '0;
          if (rxs) begin
            rx_data_d  = rx_shift;
            rx_ready_d = 1'b1;
            rx_ovr_d   = !data_read && (uart_rx_ready_o || uart_rx_ovr_o);
          end
        end else begin
          rx_cnt_d = rx_cnt + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX state and receive-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state        <= S_IDLE;
      rx_cnt          <= '0;
      rx_bit          <= '0;
      rx_shift        <= '0;
      uart_rx_data_o  <= '0;
      uart_rx_ready_o <= 1'b0;
      uart_rx_ovr_o   <= 1'b0;
    end else begin
      rx_state        <= rx_state_d;
      rx_cnt          <= rx_cnt_d;
      rx_bit          <= rx_bit_d;
      rx_shift        <= rx_shift_d;
      uart_rx_data_o  <= rx_data_d;
      uart_rx_ready_o <= rx_ready_d;
      uart_rx_ovr_o   <= rx_ovr_d;
    end
  end

endmodule
